// File: rtl/fixed_round_pipe_pkg.sv
// Shared definitions for the fixed-point rounding pipeline: rounding-mode
// encodings and a width helper used to size Q-format buses.
package fixed_pkg;

  localparam logic [1:0] RND_FLOOR     = 2'd0;
  localparam logic [1:0] RND_HALF_UP   = 2'd1;
  localparam logic [1:0] RND_HALF_EVEN = 2'd2;
  localparam logic [1:0] RND_TO_ZERO   = 2'd3;

  // Total bus width of a Q(int_wid).(frac) value, sign bit included.
  function automatic int fx_width(input int int_wid, input int frac);
    return int_wid + frac;
  endfunction

endpackage

// File: rtl/fixed_round_inc.sv
// Rounding-increment decision: maps the bits around the cut point and the
// selected mode onto the single-LSB increment applied to the kept value.
module fixed_round_inc
  import fixed_pkg::*;
(
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  input  logic       sign,
  input  logic [1:0] mode,
  output logic       inc
);

  // Increment selection per rounding mode.
  always_comb begin
    inc = 1'b0;
    case (mode)
      RND_FLOOR:     inc = 1'b0;
      RND_HALF_UP:   inc = guard;
      // Exact ties go to the even neighbour; anything above half rounds up.
      RND_HALF_EVEN: inc = guard & (sticky | lsb);
      // Floor already truncates positives toward zero; negatives with any
      // dropped fraction must move up by one to do the same.
      RND_TO_ZERO:   inc = sign & (guard | sticky);
      default:       inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fixed_round_pipe.sv
// Two-stage valid/ready rounder from Q(INT_WID).(RAT_WID) to Q(INT_WID).(OUT_RAT_WID).
// Define FIXED_ROUND_SAT_EN to saturate on overflow instead of wrapping.
module fixed_round_pipe
  import fixed_pkg::*;
#(
  parameter int INT_WID     = 10,
  parameter int RAT_WID     = 10,
  parameter int OUT_RAT_WID = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [fx_width(INT_WID, RAT_WID)-1:0]     in_data,
  input  logic [1:0]                              in_mode,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [fx_width(INT_WID, OUT_RAT_WID)-1:0] out_data,
  output logic                                    out_ovf,
  output logic                                    ovf_flag,
  input  logic                                    ovf_clr
);

  localparam int W_IN  = fx_width(INT_WID, RAT_WID);
  localparam int W_OUT = fx_width(INT_WID, OUT_RAT_WID);
  localparam int D     = RAT_WID - OUT_RAT_WID;

  if ((OUT_RAT_WID < 0) || (OUT_RAT_WID >= RAT_WID)) begin : g_bad_cfg
    $error("fixed_round_pipe: OUT_RAT_WID must satisfy 0 <= OUT_RAT_WID < RAT_WID");
  end

  logic             advance_s;
  logic             sticky_s;
  logic             inc_s;
  logic             s1_valid_r;
  logic [W_OUT-1:0] kept_r;
  logic             inc_r;
  logic [W_OUT:0]   sum_s;
  logic             ovf_s;
  logic [W_OUT-1:0] res_s;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign advance_s = ~out_valid | out_ready;
  assign in_ready  = rst_n & advance_s;

  if (D > 1) begin : g_sticky
    assign sticky_s = |in_data[D-2:0];
  end else begin : g_no_sticky
    assign sticky_s = 1'b0;
  end

  fixed_round_inc u_inc (
    .lsb    (in_data[D]),
    .guard  (in_data[D-1]),
    .sticky (sticky_s),
    .sign   (in_data[W_IN-1]),
    .mode   (in_mode),
    .inc    (inc_s)
  );

  // Stage 1: capture the arithmetically shifted value and its increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      kept_r     <= {W_OUT{1'b0}};
      inc_r      <= 1'b0;
    end else if (advance_s) begin
      s1_valid_r <= in_valid;
      kept_r     <= in_data[W_IN-1:D];
      inc_r      <= inc_s;
    end else begin
      s1_valid_r <= s1_valid_r;
      kept_r     <= kept_r;
      inc_r      <= inc_r;
    end
  end

  // Sign-extended add: the two top bits disagree only when the carry
  // reaches the sign bit, i.e. max positive plus one.
  assign sum_s = {kept_r[W_OUT-1], kept_r} + {{W_OUT{1'b0}}, inc_r};
  assign ovf_s = sum_s[W_OUT] ^ sum_s[W_OUT-1];

`ifdef FIXED_ROUND_SAT_EN
  localparam logic [W_OUT-1:0] SAT_MAX = {1'b0, {(W_OUT-1){1'b1}}};

  // Clamp the single overflow case to the largest positive code.
  always_comb begin
    res_s = sum_s[W_OUT-1:0];
    if (ovf_s) begin
      res_s = SAT_MAX;
    end else begin
      res_s = sum_s[W_OUT-1:0];
    end
  end
`else
  // Overflow wraps to the most-negative code.
  always_comb begin
    res_s = sum_s[W_OUT-1:0];
  end
`endif

  // Stage 2: registered result, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {W_OUT{1'b0}};
      out_ovf   <= 1'b0;
    end else if (advance_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_data <= res_s;
        out_ovf  <= ovf_s;
      end else begin
        out_data <= out_data;
        out_ovf  <= out_ovf;
      end
    end else begin
      out_valid <= out_valid;
      out_data  <= out_data;
      out_ovf   <= out_ovf;
    end
  end

  // Sticky overflow; a fresh overflow beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_flag <= 1'b0;
    end else if (advance_s && s1_valid_r && ovf_s) begin
      ovf_flag <= 1'b1;
    end else if (ovf_clr) begin
      ovf_flag <= 1'b0;
    end else begin
      ovf_flag <= ovf_flag;
    end
  end

endmodule

// File: tb/tb_fixed_round_pipe.sv
// Self-checking bench for fixed_round_pipe in Q4.4 -> Q4.2; honours FIXED_ROUND_SAT_EN.
module tb_fixed_round_pipe;

  localparam int IW = 4;
  localparam int RW = 4;
  localparam int OW = 2;
  localparam int WI = IW + RW;
  localparam int WO = IW + OW;
  localparam int D  = RW - OW;

`ifdef FIXED_ROUND_SAT_EN
  localparam logic [WO-1:0] EXP_OVF = 6'h1F;
`else
  localparam logic [WO-1:0] EXP_OVF = 6'h20;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WI-1:0] in_data;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [WO-1:0] out_data;
  logic          out_ovf;
  logic          ovf_flag;
  logic          ovf_clr;

  fixed_round_pipe #(.INT_WID(IW), .RAT_WID(RW), .OUT_RAT_WID(OW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: real-valued rounding on integers scaled by 2^D.
  function automatic void model(input logic [WI-1:0] d, input logic [1:0] m,
                                output logic [WO-1:0] y, output bit ovf);
    int x, k, r, half, res, maxp;
    x    = $signed(d);
    k    = x >>> D;
    r    = x - k * (1 << D);
    half = 1 << (D - 1);
    maxp = (1 << (WO - 1)) - 1;
    case (m)
      2'd0: res = k;
      2'd1: res = (r >= half) ? k + 1 : k;
      2'd2: res = (r > half) ? k + 1 : (r < half) ? k : k + (k & 1);
      default: res = (x < 0 && r != 0) ? k + 1 : k;
    endcase
    ovf = (res > maxp);
`ifdef FIXED_ROUND_SAT_EN
    if (ovf) res = maxp;
`endif
    y = res[WO-1:0];
  endfunction

  typedef struct {logic [WO-1:0] data; bit ovf;} exp_t;
  exp_t q[$];
  int   popped = 0;
  bit   prev_rst = 1'b0, prev_adv = 1'b0, prev_clr = 1'b0, mflag = 1'b0;

  // Scoreboard compare on every falling edge.
  always @(negedge clk) begin
    exp_t e;
    bit   new_item;
    if (!rst_n) begin
      check("rst_in_ready", 32'(in_ready), 32'h0);
      q.delete();
      mflag = 1'b0; prev_clr = 1'b0; prev_adv = 1'b0; prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_ovf", 32'(out_ovf), 32'h0);
      end
      new_item = out_valid && prev_adv && (q.size() > 0);
      if (new_item && q[0].ovf) mflag = 1'b1;
      else if (prev_clr) mflag = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("mon_unexpected_valid", 32'(out_valid), 32'h0);
        end else begin
          check("mon_data", 32'(out_data), 32'(q[0].data));
          check("mon_ovf", 32'(out_ovf), 32'(q[0].ovf));
        end
      end
      check("mon_ovf_flag", 32'(ovf_flag), 32'(mflag));
      check("mon_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        popped++;
      end
      if (in_valid && in_ready) begin
        model(in_data, in_mode, e.data, e.ovf);
        q.push_back(e);
      end
      prev_adv = !out_valid || out_ready;
      prev_clr = ovf_clr;
      prev_rst = 1'b0;
    end
  end

  task automatic send_one(input logic [WI-1:0] d, input logic [1:0] m,
                          input logic [WO-1:0] e, input string nm);
    int waited = 0;
    in_valid = 1'b1; in_data = d; in_mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    do begin @(negedge clk); waited++; end while (!out_valid && waited < 6);
    check({nm, "_lat"}, 32'(waited), 32'd2);
    check(nm, 32'(out_data), 32'(e));
  endtask

  task automatic push_item(input logic [WI-1:0] d, input logic [1:0] m);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_mode = m;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    check("push_timeout", 32'(t < 50), 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WO-1:0] y;
    bit            o;
    int            p0, t;
    logic [WI-1:0] bp [3];
    bp[0] = 8'h04; bp[1] = 8'h08; bp[2] = 8'h0C;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_mode = 2'd0;
    out_ready = 1'b1; ovf_clr = 1'b0;

    // Hand-computed pins on the model itself.
    model(8'h06, 2'd1, y, o); check("model_06_m1", 32'(y), 32'h02);
    model(8'hFA, 2'd3, y, o); check("model_FA_m3", 32'(y), 32'h3F);
    model(8'h02, 2'd2, y, o); check("model_02_m2", 32'(y), 32'h00);
    model(8'h7F, 2'd1, y, o); check("model_7F_m1", 32'(y), 32'(EXP_OVF));
    check("model_7F_ovf", 32'(o), 32'h1);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ovf_flag", 32'(ovf_flag), 32'h0);
    @(posedge clk); #1;

    for (int m = 0; m < 4; m++) send_one(8'h05, 2'(m), 6'h01, "sweep_05");
    send_one(8'h06, 2'd0, 6'h01, "sweep_06_m0");
    send_one(8'h06, 2'd1, 6'h02, "sweep_06_m1");
    send_one(8'h06, 2'd2, 6'h02, "sweep_06_m2");
    send_one(8'h06, 2'd3, 6'h01, "sweep_06_m3");
    send_one(8'h02, 2'd1, 6'h01, "sweep_02_m1");
    send_one(8'h02, 2'd2, 6'h00, "sweep_02_m2");
    send_one(8'hFA, 2'd0, 6'h3E, "neg_FA_m0");
    send_one(8'hFA, 2'd1, 6'h3F, "neg_FA_m1");
    send_one(8'hFA, 2'd2, 6'h3E, "neg_FA_m2");
    send_one(8'hFA, 2'd3, 6'h3F, "neg_FA_m3");
    @(posedge clk); #1;

    // Overflow, then clear racing a second overflow, then a plain clear.
    in_valid = 1'b1; in_data = 8'h7F; in_mode = 2'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0; ovf_clr = 1'b1;
    @(negedge clk);
    check("ovf_data", 32'(out_data), 32'(EXP_OVF));
    check("ovf_out_ovf", 32'(out_ovf), 32'h1);
    check("ovf_flag_set", 32'(ovf_flag), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("ovf_set_wins", 32'(ovf_flag), 32'h1);
    check("ovf_second_out_ovf", 32'(out_ovf), 32'h1);
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 32'(ovf_flag), 32'h0);
    @(posedge clk); #1;

    // Back-pressure: three stall cycles after the first result appears.
    p0 = popped;
    fork
      begin
        for (int i = 0; i < 3; i++) push_item(bp[i], 2'd0);
      end
      begin
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!out_valid && t < 20);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_hold_data", 32'(out_data), 32'h01);
          check("bp_hold_valid", 32'(out_valid), 32'h1);
          check("bp_in_ready", 32'(in_ready), 32'h0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("bp_count", 32'(popped - p0), 32'd3);
    check("bp_drained", 32'(q.size()), 32'd0);

    // Throughput: eight back-to-back samples.
    in_valid = 1'b1; in_data = 8'($urandom); in_mode = 2'($urandom);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) check("tp_accept", 32'(in_ready), 32'h1);
      if (k >= 3 && k <= 10) check("tp_valid", 32'(out_valid), 32'h1);
      else check("tp_idle", 32'(out_valid), 32'h0);
      @(posedge clk); #1;
      if (k < 8) begin
        in_data = 8'($urandom); in_mode = 2'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end

    // Reset with both stages full.
    in_valid = 1'b1; in_data = 8'h7F; in_mode = 2'd1;
    @(posedge clk); #1;
    in_data = 8'h05;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("prerst_valid", 32'(out_valid), 32'h1);
    check("prerst_flag", 32'(ovf_flag), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 32'(out_valid), 32'h0);
    check("rst_mid_data", 32'(out_data), 32'h0);
    check("rst_mid_flag", 32'(ovf_flag), 32'h0);
    repeat (4) begin
      @(negedge clk);
      check("rst_no_ghost", 32'(out_valid), 32'h0);
    end
    @(posedge clk); #1;

    // Randomised traffic with stalls, clears and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      in_data   = ($urandom_range(7, 0) == 0) ? 8'h7F : 8'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom_range(2, 0) != 0);
      ovf_clr   = ($urandom_range(7, 0) == 0);
      rst_n     = ($urandom_range(499, 0) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("final_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_round_pipe.md
Name: fixed_round_pipe

Overview:
- Parametrised, pipelined fixed-point rounder. Reduces a signed two's-complement Q(INT_WID).(RAT_WID) sample to Q(INT_WID).(OUT_RAT_WID).
- Four run-time rounding modes, overflow saturation and a sticky overflow flag.
- Valid/ready stream interface on both sides, so it drops between fixed-point arithmetic stages without external flow-control glue.

Parameters:
- INT_WID, 10, integer bits including sign.
- RAT_WID, 10, input fractional bits.
- OUT_RAT_WID, 4, output fractional bits. Legal range 0 <= OUT_RAT_WID < RAT_WID; elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  INT_WID+RAT_WID  signed input sample
- in_mode  in  2  rounding mode, sampled with in_data
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_data  out  INT_WID+OUT_RAT_WID  rounded signed result
- out_ovf  out  1  overflow occurred on this out_data sample
- ovf_flag  out  1  sticky overflow flag
- ovf_clr  in  1  clears ovf_flag

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset values (rst_n low at a clock edge): out_valid=0, out_data=0, out_ovf=0, ovf_flag=0, all internal valids=0.
- in_ready is 0 while rst_n is low.
- Reset mid-operation discards in-flight samples; nothing is emitted for them.
- Definitions: D = RAT_WID-OUT_RAT_WID dropped bits.
  - kept = in_data >> D, arithmetic.
  - lsb = in_data[D].
  - guard = in_data[D-1].
  - sticky = OR of in_data[D-2:0], or 0 when D=1.
  - sign = MSB.
- Modes, giving increment inc:
  - 0 truncate/floor: inc=0.
  - 1 round-half-up: inc=guard.
  - 2 round-half-even: inc=guard&(sticky|lsb).
  - 3 toward-zero: inc=sign&(guard|sticky).
  - Modes are per-sample; changing in_mode between samples is legal.
- Pipeline, two stages:
  - S1 registers kept, inc and valid.
  - S2 computes kept+inc, applies overflow handling and registers out_data/out_ovf/out_valid.
- Flow control: advance = !out_valid | out_ready; in_ready = advance (when rst_n high).
  - When advance=1: S1 loads the input handshake (valid = in_valid & in_ready); S2 loads from S1.
  - When advance=0: both stages hold.
  - Latency: 2 cycles from accept to out_valid with no stall. Throughput: 1 sample per cycle with out_ready held high.
- out_data is stable while out_valid=1 and out_ready=0.
- Overflow arithmetic:
  - Only kept = max positive (0 followed by all 1s) with inc=1 overflows; negative values cannot overflow.
  - The add is performed at width+1, and overflow = carry into the sign bit.
- ovf_flag:
  - Set on the cycle S2 loads an overflowing sample.
  - ovf_clr clears it.
  - Simultaneous set and clear: set wins.

Optional Feature:
- Macro: FIXED_ROUND_SAT_EN.
- Defined: on overflow, out_data = max positive (0 followed by all 1s).
- Undefined: out_data wraps, e.g. most-negative for the single overflow case.
- In both builds: out_ovf and ovf_flag are set; latency and handshake are identical.

Decomposition:
- Shared package fixed_pkg holds:
  - round mode constants RND_FLOOR=0, RND_HALF_UP=1, RND_HALF_EVEN=2, RND_TO_ZERO=3;
  - a width helper function for INT_WID+frac.
- One natural sub-module: fixed_round_inc. Purely combinational (lsb, guard, sticky, sign, mode) -> inc; instantiated in S1.

Test Plan:
- Bench config: INT_WID=4, RAT_WID=4, OUT_RAT_WID=2 (Q4.4 -> Q4.2).
- Mode sweep, positive inputs:
  - in_data=0x05 -> 0x01 in all modes.
  - 0x06 -> mode0 0x01, mode1 0x02, mode2 0x02, mode3 0x01.
  - 0x02 -> mode1 0x01, mode2 0x00.
- Negative input in_data=0xFA (-0.375) -> mode0 0x3E, mode1 0x3F, mode2 0x3E, mode3 0x3F.
- Overflow, in_data=0x7F with mode1:
  - FIXED_ROUND_SAT_EN defined -> out_data=0x1F.
  - Undefined -> 0x20.
  - Both builds: out_ovf=1, ovf_flag=1.
  - Then ovf_clr=1 with the same overflow arriving in S2 that cycle -> ovf_flag stays 1.
  - Next cycle, ovf_clr=1 with no overflow -> 0.
- Back-pressure:
  - Stream 0x04,0x08,0x0C with out_ready=0 for 3 cycles after the first out_valid.
  - Required: out_data=0x01 holds stable, in_ready=0 while stalled.
  - Then outputs 0x01,0x02,0x03 in order with no loss or duplicate.
- Throughput/latency:
  - 8 back-to-back samples with out_ready=1.
  - First out_valid exactly 2 cycles after first accept; 8 consecutive valid cycles.
- Reset mid-stream:
  - rst_n low for 1 cycle with both stages full.
  - Required: next cycle out_valid=0, out_data=0, ovf_flag=0; the pre-reset samples never appear.
